// File: rtl/rfarb_pkg.sv
// rfarb_pkg: shared encodings for the register-file write arbiter.
package rfarb_pkg;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_WB = 2'd1, SRC_TRAP = 2'd2, SRC_UART = 2'd3} src_t;
  typedef enum logic {IDLE = 1'b0, TRAP_PEND = 1'b1} state_t;
  localparam logic [4:0] REG_K0 = 5'd26;
endpackage

// File: rtl/rfarb_fifo.sv
// rfarb_fifo: synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module rfarb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between WB, trap $k0 save and UART bytes.
// Define RFARB_UART_EN to build the UART FIFO, starvation counter and overflow flag.
module regfile_wr_arbiter
  import rfarb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8,
  parameter logic [4:0] UART_REG0 = 5'd24,
  parameter logic [4:0] UART_REG1 = 5'd25
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_RegWrite,
  input  logic [4:0]                    wb_WriteRegister,
  input  logic [31:0]                   wb_RegWriteData,
  input  logic                          trap_req,
  input  logic [31:0]                   trap_data,
  input  logic                          uart_signal,
  input  logic                          uart_flag,
  input  logic [7:0]                    uart_rx_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic [1:0]                    rf_src,
  output logic                          arb_stall,
  output logic                          trap_pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_overflow
);
  state_t state, state_nx;
  logic [31:0] trap_q;
  logic wb_req, pend, trap_live, head_valid;
  logic g_wb, g_trap, g_uart;
  logic [4:0] head_dest;
  logic [7:0] head_byte;
  assign wb_req = wb_RegWrite && (wb_WriteRegister != 5'd0);
  assign pend = state == TRAP_PEND;
  assign trap_live = trap_req && state == IDLE;
  assign g_wb = rst_n && wb_req;
  assign g_trap = rst_n && !wb_req && (trap_live || pend);
  assign g_uart = rst_n && !wb_req && !trap_live && !pend && head_valid;
  assign trap_pending = pend;
  always_comb begin
    rf_we = g_wb | g_trap | g_uart;
    rf_src = g_wb ? SRC_WB : g_trap ? SRC_TRAP : g_uart ? SRC_UART : SRC_NONE;
    rf_waddr = g_wb ? wb_WriteRegister : g_trap ? REG_K0 : g_uart ? head_dest : 5'd0;
    rf_wdata = g_wb ? wb_RegWriteData : g_trap ? (pend ? trap_q : trap_data) : g_uart ? {24'd0, head_byte} : 32'd0;
    state_nx = (pend && !wb_req) ? IDLE : (trap_live && wb_req) ? TRAP_PEND : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else begin
      state <= state_nx;
      if (trap_live && wb_req) trap_q <= trap_data;
    end
  end
`ifdef RFARB_UART_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  logic full, empty;
  rfarb_fifo #(.DEPTH(FIFO_DEPTH), .W(13)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (uart_signal),
    .pop   (g_uart),
    .din   ({uart_flag ? UART_REG1 : UART_REG0, uart_rx_data}),
    .dout  ({head_dest, head_byte}),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  assign head_valid = !empty;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve <= '0;
      uart_overflow <= 1'b0;
    end else begin
      starve <= (empty || g_uart) ? '0 : (starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1);
      uart_overflow <= uart_overflow | (uart_signal & full & !g_uart);
    end
  end
  assign arb_stall = rst_n && (pend || starve == SW'(STARVE_MAX));
`else
  logic unused_uart;
  assign unused_uart = ^{uart_signal, uart_flag, uart_rx_data, UART_REG0, UART_REG1, 32'(STARVE_MAX)};
  assign head_valid = 1'b0;
  assign head_dest = 5'd0;
  assign head_byte = 8'd0;
  assign fifo_count = '0;
  assign uart_overflow = 1'b0;
  assign arb_stall = rst_n && pend;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random stimulus against a queue-based reference model.
module tb_regfile_wr_arbiter;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;
`ifdef RFARB_UART_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, wb_RegWrite, trap_req, uart_signal, uart_flag;
  logic [4:0] wb_WriteRegister;
  logic [31:0] wb_RegWriteData, trap_data;
  logic [7:0] uart_rx_data;
  logic rf_we, arb_stall, trap_pending, uart_overflow;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0] rf_src;
  logic [2:0] fifo_count;
  int checks = 0;
  int errors = 0;
  bit [12:0] q[$];
  bit pend_v;
  bit [31:0] pend_d;
  int starve;
  bit ovf;
  logic obs_we;
  logic [1:0] obs_src;
  logic [4:0] obs_addr;
  logic [31:0] obs_data;
  int bias;

  regfile_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .wb_RegWrite(wb_RegWrite), .wb_WriteRegister(wb_WriteRegister),
    .wb_RegWriteData(wb_RegWriteData), .trap_req(trap_req), .trap_data(trap_data),
    .uart_signal(uart_signal), .uart_flag(uart_flag), .uart_rx_data(uart_rx_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
    .arb_stall(arb_stall), .trap_pending(trap_pending), .fifo_count(fifo_count),
    .uart_overflow(uart_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit we, input bit [4:0] wa, input bit [31:0] wd,
                      input bit tr, input bit [31:0] td, input bit us, input bit uf, input bit [7:0] ub);
    bit wbq, gu;
    bit [1:0] e_src;
    bit [4:0] e_addr;
    bit [31:0] e_data;
    rst_n = r; wb_RegWrite = we; wb_WriteRegister = wa; wb_RegWriteData = wd;
    trap_req = tr; trap_data = td; uart_signal = us; uart_flag = uf; uart_rx_data = ub;
    wbq = we && wa != 5'd0;
    gu = 1'b0; e_src = 2'd0; e_addr = 5'd0; e_data = 32'd0;
    if (!r) ;
    else if (wbq) begin e_src = 2'd1; e_addr = wa; e_data = wd; end
    else if (pend_v) begin e_src = 2'd2; e_addr = 5'd26; e_data = pend_d; end
    else if (tr) begin e_src = 2'd2; e_addr = 5'd26; e_data = td; end
    else if (q.size() > 0) begin e_src = 2'd3; e_addr = q[0][12:8]; e_data = {24'd0, q[0][7:0]}; gu = 1'b1; end
    @(negedge clk);
    obs_we = rf_we; obs_src = rf_src; obs_addr = rf_waddr; obs_data = rf_wdata;
    chk("rf_we", 32'(rf_we), 32'(e_src != 2'd0));
    chk("rf_src", 32'(rf_src), 32'(e_src));
    chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
    chk("rf_wdata", rf_wdata, e_data);
    @(posedge clk);
    if (!r) begin
      q.delete(); pend_v = 1'b0; starve = 0; ovf = 1'b0;
    end else begin
      if (!pend_v && tr && wbq) begin pend_v = 1'b1; pend_d = td; end
      else if (pend_v && !wbq) pend_v = 1'b0;
      starve = (q.size() == 0 || gu) ? 0 : (starve < SMAX ? starve + 1 : SMAX);
      if (gu) void'(q.pop_front());
      if (UEN && us) begin
        if (q.size() < DEPTH) q.push_back({uf ? 5'd25 : 5'd24, ub});
        else ovf = 1'b1;
      end
    end
    #1;
    chk("trap_pending", 32'(trap_pending), 32'(pend_v));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("uart_overflow", 32'(uart_overflow), 32'(ovf));
    chk("arb_stall", 32'(arb_stall), 32'(pend_v || starve == SMAX));
  endtask

  task automatic idle();
    step(1, 0, 5'd0, 32'd0, 0, 32'd0, 0, 0, 8'd0);
  endtask

  initial begin
    rst_n = 0; wb_RegWrite = 0; wb_WriteRegister = 0; wb_RegWriteData = 0;
    trap_req = 0; trap_data = 0; uart_signal = 0; uart_flag = 0; uart_rx_data = 0;
    pend_v = 0; pend_d = 0; starve = 0; ovf = 0;
    step(0, 1, 5'd3, 32'h55, 1, 32'h77, 1, 0, 8'h11);
    step(0, 0, 5'd0, 32'd0, 0, 32'd0, 0, 0, 8'd0);
    chk("reset_we", 32'(obs_we), 32'd0);
    chk("reset_stall", 32'(arb_stall), 32'd0);
    // WB and trap collide: WB wins, trap is saved a cycle later
    step(1, 1, 5'd8, 32'h1234, 1, 32'h00400010, 0, 0, 8'd0);
    chk("tp1_waddr", 32'(obs_addr), 32'd8);
    chk("tp1_pend", 32'(trap_pending), 32'd1);
    chk("tp1_stall", 32'(arb_stall), 32'd1);
    step(1, 1, 5'd9, 32'h9, 1, 32'hBAD0BAD0, 0, 0, 8'd0);
    idle();
    chk("tp1_k0_addr", 32'(obs_addr), 32'd26);
    chk("tp1_k0_data", obs_data, 32'h00400010);
    chk("tp1_pend_clr", 32'(trap_pending), 32'd0);
    step(1, 1, 5'd0, 32'hFFFF, 1, 32'hDEADBEEF, 0, 0, 8'd0);
    chk("tp2_addr", 32'(obs_addr), 32'd26);
    chk("tp2_data", obs_data, 32'hDEADBEEF);
    chk("tp2_pend", 32'(trap_pending), 32'd0);
    step(1, 0, 5'd0, 32'd0, 0, 32'd0, 1, 1, 8'hA5);
    chk("tp3_nobypass", 32'(obs_we), 32'd0);
    idle();
`ifdef RFARB_UART_EN
    chk("tp3_addr", 32'(obs_addr), 32'd25);
    chk("tp3_data", obs_data, 32'h000000A5);
    chk("tp3_src", 32'(obs_src), 32'd3);
`else
    chk("tp3_ignored", 32'(obs_we), 32'd0);
`endif
    for (int i = 0; i < 5; i++) step(1, 1, 5'd10, 32'(i), 0, 32'd0, 1, i[0], 8'(8'h30 + i));
    chk("tp4_count", 32'(fifo_count), UEN ? 32'd4 : 32'd0);
    chk("tp4_ovf", 32'(uart_overflow), 32'(UEN));
    for (int i = 0; i < 9; i++) step(1, 1, 5'd11, 32'(i), 0, 32'd0, 0, 0, 8'd0);
    chk("tp5_stall", 32'(arb_stall), 32'(UEN));
    idle();
`ifdef RFARB_UART_EN
    chk("tp5_head_addr", 32'(obs_addr), 32'd24);
    chk("tp5_head_data", obs_data, 32'h00000030);
`endif
    chk("tp5_stall_clr", 32'(arb_stall), 32'd0);
    chk("tp5_ovf_sticky", 32'(uart_overflow), 32'(UEN));
    step(1, 1, 5'd12, 32'h12, 1, 32'h0BADF00D, 0, 0, 8'd0);
    chk("tp6_pend", 32'(trap_pending), 32'd1);
    step(0, 0, 5'd0, 32'd0, 0, 32'd0, 0, 0, 8'd0);
    chk("tp6_pend_clr", 32'(trap_pending), 32'd0);
    chk("tp6_count", 32'(fifo_count), 32'd0);
    chk("tp6_ovf", 32'(uart_overflow), 32'd0);
    idle();
    chk("tp6_we", 32'(obs_we), 32'd0);
    chk("tp6_stall", 32'(arb_stall), 32'd0);
    bias = 2;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) bias = int'($urandom_range(0, 4));
      step($urandom_range(0, 63) != 0, int'($urandom_range(0, 3)) < bias, 5'($urandom_range(0, 31)),
           $urandom, $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 2) == 0,
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Single-port write arbiter for the register file. It shares one write port between three requesters: WB-stage writeback, the interrupt/exception $k0 save, and UART receive bytes. UART bytes are buffered in a small FIFO. Sits between WB/ID control and the RegisterFile write side; asserts a pipeline stall when a trap save or starved UART byte cannot otherwise be written.

## Interface
- FIFO_DEPTH, 4, UART byte FIFO entries (power of 2, ≥2)
- STARVE_MAX, 8, cycles a non-empty FIFO head may wait before stall is forced
- UART_REG0, 5'd24, destination register when uart_flag=0
- UART_REG1, 5'd25, destination register when uart_flag=1
- clk  in  1  clock, all state on posedge
- rst_n  in  1  reset, synchronous, active-low
- wb_RegWrite  in  1  WB write request
- wb_WriteRegister  in  5  WB destination
- wb_RegWriteData  in  32  WB data
- trap_req  in  1  one-cycle pulse: interrupt/exception save requested
- trap_data  in  32  value to save into $k0
- uart_signal  in  1  one-cycle pulse: new byte
- uart_flag  in  1  selects UART_REG0/UART_REG1
- uart_rx_data  in  8  received byte
- rf_we  out  1  register file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- rf_src  out  2  granted source (NONE/WB/TRAP/UART)
- arb_stall  out  1  freeze PC/IF_ID, bubble ID_EX
- trap_pending  out  1  trap save latched, not yet written
- fifo_count  out  $clog2(FIFO_DEPTH)+1  UART entries held
- uart_overflow  out  1  sticky: byte dropped

## Operation
- Priority per cycle: WB > trap (live or pending) > UART FIFO head.
- WB with wb_WriteRegister==0 is not a request; lower sources may use the port.
- Trap: writes $k0 (5'd26) with trap_data. If not granted in its cycle, latch data, state IDLE→TRAP_PEND. In TRAP_PEND, grant as soon as WB idle; then →IDLE. trap_req while TRAP_PEND ignored (first trap wins).
- UART: on uart_signal push {dest, byte}; data written zero-extended {24'b0, byte}. Full and no pop same cycle → byte dropped, uart_overflow set until reset. Full with pop same cycle → push accepted. No bypass: a byte pushed into an empty FIFO is writable no earlier than the next cycle.
- Starvation counter: increments each cycle FIFO non-empty and head not granted; clears on UART grant or empty; saturates at STARVE_MAX.
- arb_stall = trap_pending | (starve_cnt == STARVE_MAX). Pipeline drains to bubbles, so WB goes idle within 3 cycles of stall.
- rf_src encodes the granted source; NONE when rf_we=0.

## Timing
- rf_we/rf_waddr/rf_wdata/rf_src combinational from current inputs plus registered state: WB and live trap granted zero-latency; pending trap and FIFO head from registered state.
- trap_pending, fifo_count, uart_overflow, starve counter, FIFO registered.
- Reset (rst_n low at posedge): state IDLE, FIFO empty, counter 0, uart_overflow 0. All outputs read 0 (rf_* 0, rf_src NONE, arb_stall 0) while in reset state. Reset mid-trap discards the pending save. Reset mid-FIFO discards buffered bytes.
- Pointers wrap modulo FIFO_DEPTH. Count distinguishes full from empty.

## Configuration
- RFARB_UART_EN defined: UART FIFO, starvation counter and uart_overflow built.
- Undefined: uart_* inputs ignored; fifo_count and uart_overflow tied 0; arb_stall = trap_pending only.

## Structure
- Package rfarb_pkg: source encoding SRC_NONE=0, SRC_WB=1, SRC_TRAP=2, SRC_UART=3; REG_K0=5'd26; state encoding IDLE/TRAP_PEND.
- Sub-module rfarb_fifo: synchronous FIFO of {5-bit dest, 8-bit byte} with push/pop/full/empty/count; instantiated only under RFARB_UART_EN.

## Test plan
- WB write $8=0x1234 with trap_req (trap_data=0x00400010) same cycle → cycle 0 writes $8; trap_pending=1, arb_stall=1; next cycle with WB idle, write $26=0x00400010 and trap_pending=0.
- WB to $0 with trap_req → trap writes $26 same cycle; trap_pending stays 0.
- uart_signal byte 0xA5, flag=1, WB idle → next cycle rf_waddr=25, rf_wdata=0x000000A5, rf_src=UART.
- 5 bytes pushed back-to-back while WB busy every cycle (DEPTH=4) → fifo_count=4, 5th dropped, uart_overflow=1 until reset.
- FIFO non-empty with WB busy continuously → arb_stall rises after 8 cycles; first WB-idle cycle writes the UART head; stall clears.
- rst_n low during TRAP_PEND with 3 FIFO entries → next cycle trap_pending=0, fifo_count=0, rf_we=0, arb_stall=0.
